// File: rtl/inscache.sv
// Zero-latency direct-mapped instruction cache for insfetch with even/odd word banks,
// so an RV32C window that straddles two words is looked up in a single cycle.
module inscache #(
  parameter int unsigned INDEX_W = 7
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] in_PC,
  input  logic        ask_for,
  output logic        give_you,
  output logic [31:0] g_ins,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int unsigned DEPTH = 1 << INDEX_W;
  localparam int unsigned TAG_W = 29 - INDEX_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]       state;
  logic [DEPTH-1:0] valid_e, valid_o;
  logic [TAG_W-1:0] tag_e  [DEPTH];
  logic [TAG_W-1:0] tag_o  [DEPTH];
  logic [31:0]      data_e [DEPTH];
  logic [31:0]      data_o [DEPTH];

  logic [29:0]        w0, w1, miss_w;
  logic [INDEX_W-1:0] e_idx, o_idx, f_idx;
  logic [TAG_W-1:0]   e_tag, o_tag, f_tag;
  logic               e_hit, o_hit, w0_hit, w1_hit, need1, hit, fill_we, f_bank;
  logic [31:0]        w0_dat, w1_dat, window;
  logic               unused_bits;

  assign w0 = in_PC[31:2];
  assign w1 = w0 + 30'd1;
  assign unused_bits = ^{in_PC[0], w1[0]};

  // word0 and word1 always live in opposite banks; route each word to its bank
  assign e_idx = w0[0] ? w1[INDEX_W:1]       : w0[INDEX_W:1];
  assign e_tag = w0[0] ? w1[29:INDEX_W+1]    : w0[29:INDEX_W+1];
  assign o_idx = w0[0] ? w0[INDEX_W:1]       : w1[INDEX_W:1];
  assign o_tag = w0[0] ? w0[29:INDEX_W+1]    : w1[29:INDEX_W+1];

  assign e_hit = valid_e[e_idx] && (tag_e[e_idx] == e_tag);
  assign o_hit = valid_o[o_idx] && (tag_o[o_idx] == o_tag);

  assign w0_hit = w0[0] ? o_hit : e_hit;
  assign w1_hit = w0[0] ? e_hit : o_hit;
  assign w0_dat = w0[0] ? data_o[o_idx] : data_e[e_idx];
  assign w1_dat = w0[0] ? data_e[e_idx] : data_o[o_idx];

  always_comb begin
    need1  = in_PC[1] && (w0_dat[17:16] == 2'b11);
    hit    = w0_hit && (!need1 || w1_hit);
    miss_w = w0_hit ? w1 : w0;
    if (!in_PC[1])
      window = w0_dat;
    else if (need1)
      window = {w1_dat[15:0], w0_dat[31:16]};
    else
      window = {16'h0000, w0_dat[31:16]};
  end

  assign give_you = ask_for && hit && (state == IDLE);
  assign g_ins    = give_you ? window : '0;

  assign f_bank  = mem_addr[2];
  assign f_idx   = mem_addr[INDEX_W+2:3];
  assign f_tag   = mem_addr[31:INDEX_W+3];
  assign fill_we = (state == FILL) && rdy_in && mem_ack;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      valid_e  <= '0;
      valid_o  <= '0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (ask_for && !hit) begin
            mem_addr <= {miss_w, 2'b00};
            mem_req  <= 1'b1;
            state    <= FILL;
          end
        end
        default: begin
          if (mem_ack) begin
            if (f_bank) valid_o[f_idx] <= 1'b1;
            else        valid_e[f_idx] <= 1'b1;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      if (f_bank) begin
        tag_o[f_idx]  <= f_tag;
        data_o[f_idx] <= mem_data;
      end else begin
        tag_e[f_idx]  <= f_tag;
        data_e[f_idx] <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_inscache.sv
// Bench for inscache: directed scenarios plus randomized fetch traffic against a
// word-slot model of the cache that tracks which word address each slot holds.
module tb_inscache;

  localparam int unsigned IW    = 7;
  localparam int unsigned NSLOT = 1 << (IW + 1);

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, ask_for, give_you, mem_req, mem_ack;
  logic [31:0] in_PC, g_ins, mem_addr, mem_data;

  inscache #(.INDEX_W(IW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .in_PC(in_PC),
    .ask_for(ask_for), .give_you(give_you), .g_ins(g_ins), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // backing memory, word-addressed; unknown words are invented on first touch
  logic [31:0] mem [bit [29:0]];

  function automatic logic [31:0] memword(input bit [29:0] w);
    if (!mem.exists(w)) begin
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v[17:16] = 2'b11;
      mem[w] = v;
    end
    return mem[w];
  endfunction

  // model: each slot (word address mod NSLOT) remembers the word address and data it holds
  bit          m_valid [NSLOT];
  bit [29:0]   m_word  [NSLOT];
  logic [31:0] m_data  [NSLOT];
  bit          m_pending;
  bit [29:0]   m_fill;
  int          cnt;
  int          ack_dly  = -1;
  bit          auto_ack = 1'b1;
  bit          prev_req;
  logic [31:0] fill_log [$];

  function automatic bit mhit(input bit [29:0] w);
    int s;
    s = int'(w % 30'(NSLOT));
    return m_valid[s] && (m_word[s] == w);
  endfunction

  function automatic void lookup(input logic [31:0] pc, output bit h,
                                 output bit [29:0] missing, output logic [31:0] ins);
    bit [29:0]   w0, w1;
    logic [31:0] d0, d1;
    w0 = pc[31:2];
    w1 = w0 + 30'd1;
    h = 1'b0; missing = w0; ins = '0;
    if (!mhit(w0)) return;
    d0 = m_data[int'(w0 % 30'(NSLOT))];
    if (!pc[1]) begin
      h = 1'b1; ins = d0;
    end else if (d0[17:16] != 2'b11) begin
      h = 1'b1; ins = {16'h0000, d0[31:16]};
    end else if (!mhit(w1)) begin
      missing = w1;
    end else begin
      d1 = m_data[int'(w1 % 30'(NSLOT))];
      h = 1'b1; ins = {d1[15:0], d0[31:16]};
    end
  endfunction

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_pending = 1'b0;
    m_fill    = '0;
    prev_req  = 1'b0;
  endtask

  task automatic model_step();
    bit          h;
    bit [29:0]   ms;
    logic [31:0] ins;
    int          s;
    if (!rdy_in) return;
    if (!m_pending) begin
      lookup(in_PC, h, ms, ins);
      if (ask_for && !h) begin
        m_pending = 1'b1;
        m_fill    = ms;
        cnt       = (ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 4));
      end
    end else if (mem_ack) begin
      s = int'(m_fill % 30'(NSLOT));
      m_valid[s] = 1'b1;
      m_word[s]  = m_fill;
      m_data[s]  = mem_data;
      m_pending  = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit          h, eg;
    bit [29:0]   ms;
    logic [31:0] ins;
    lookup(in_PC, h, ms, ins);
    eg = ask_for && h && !m_pending;
    check("give_you", 32'(give_you), 32'(eg));
    check("g_ins", g_ins, eg ? ins : 32'h0);
    check("mem_req", 32'(mem_req), 32'(m_pending));
    check("mem_addr", mem_addr, {m_fill, 2'b00});
  endtask

  // one clock: drive the memory side, advance model at the edge, check just after it
  task automatic step();
    if (auto_ack) begin
      mem_ack = 1'b0;
      if (m_pending && rdy_in) begin
        if (cnt == 0) begin
          mem_ack  = 1'b1;
          mem_data = memword(m_fill);
        end else cnt--;
      end
    end
    @(posedge clk_in);
    model_step();
    #1;
    check_outputs();
    if (mem_req && !prev_req) fill_log.push_back(mem_addr);
    prev_req = mem_req;
  endtask

  task automatic run_until_give(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = give_you;
    end
    check("give_timeout", 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    rst_in  = 1'b1;
    mem_ack = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_give", 32'(give_you), 32'd0);
    rst_in = 1'b0;
    fill_log.delete();
  endtask

  task automatic ask(input logic [31:0] pc);
    in_PC   = pc;
    ask_for = 1'b1;
  endtask

  logic [31:0] bases [4] = '{32'h0000_0000, 32'h0000_0800, 32'h1234_5000, 32'hFFFF_FF80};

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; ask_for = 1'b0; in_PC = '0;
    mem_ack = 1'b0; mem_data = '0;
    do_reset();

    // single-word miss, fixed ack delay
    mem[30'h0] = 32'h0000_0513;
    ack_dly = 2;
    ask(32'h0);
    run_until_give(20);
    check("t1_ins", g_ins, 32'h0000_0513);
    repeat (5) step();
    check("t1_nfill", 32'(fill_log.size()), 32'd1);
    check("t1_addr", fill_log[0], 32'h0);

    // window spanning two words
    do_reset();
    mem[30'h0] = 32'h0293_0000;
    mem[30'h1] = 32'h0000_0050;
    ask(32'h2);
    run_until_give(40);
    check("t2_ins", g_ins, 32'h0050_0293);
    check("t2_nfill", 32'(fill_log.size()), 32'd2);
    check("t2_a0", fill_log[0], 32'h0);
    check("t2_a1", fill_log[1], 32'h4);

    // compressed upper half needs only one word
    do_reset();
    mem[30'h1] = 32'h4505_0000;
    ask(32'h6);
    run_until_give(40);
    check("t3_ins", g_ins, 32'h0000_4505);
    repeat (3) step();
    check("t3_nfill", 32'(fill_log.size()), 32'd1);
    check("t3_a0", fill_log[0], 32'h4);

    // index conflict between 0x0 and 0x800
    do_reset();
    mem[30'h0]   = 32'h0000_0013;
    mem[30'h200] = 32'h0010_0093;
    ask(32'h0);
    run_until_give(20);
    fill_log.delete();
    ask(32'h800);
    run_until_give(20);
    check("t4_ins", g_ins, 32'h0010_0093);
    check("t4_a0", fill_log[0], 32'h800);
    fill_log.delete();
    ask(32'h0);
    step();
    check("t4_miss", 32'(give_you), 32'd0);
    run_until_give(20);
    check("t4_a1", fill_log[0], 32'h0);

    // asynchronous reset while a fill is outstanding
    ask(32'h0);
    step();
    check("t6_hit", 32'(give_you), 32'd1);
    auto_ack = 1'b0;
    ask(32'h40);
    step();
    check("t6_req", 32'(mem_req), 32'd1);
    rst_in = 1'b1;
    model_reset();
    #1;
    check("t6_async", 32'(mem_req), 32'd0);
    #1;
    rst_in   = 1'b0;
    ask_for  = 1'b0;
    mem_ack  = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    step();
    mem_ack  = 1'b0;
    auto_ack = 1'b1;
    fill_log.delete();
    ask(32'h0);
    step();
    check("t6_miss", 32'(give_you), 32'd0);
    run_until_give(20);
    check("t6_ins", g_ins, 32'h0000_0013);
    check("t6_a0", fill_log[0], 32'h0);

    // redirect while filling
    do_reset();
    ack_dly = 3;
    mem[30'h4] = 32'h1111_1113;
    mem[30'h8] = 32'h2222_2223;
    ask(32'h10);
    step();
    check("t5_req", 32'(mem_req), 32'd1);
    in_PC = 32'h20;
    run_until_give(40);
    check("t5_ins", g_ins, 32'h2222_2223);
    check("t5_nfill", 32'(fill_log.size()), 32'd2);
    check("t5_a0", fill_log[0], 32'h10);
    check("t5_a1", fill_log[1], 32'h20);

    // address wrap: word1 of the top halfword is word 0
    do_reset();
    mem[30'h3FFF_FFFF] = 32'h1237_0000;
    mem[30'h0]         = 32'hABCD_5678;
    ask(32'hFFFF_FFFE);
    run_until_give(40);
    check("wrap_ins", g_ins, 32'h5678_1237);
    check("wrap_a0", fill_log[0], 32'hFFFF_FFFC);
    check("wrap_a1", fill_log[1], 32'h0);

    // random traffic: redirects, idle cycles, stalls
    do_reset();
    ack_dly = -1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        in_PC = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 63) * 2);
      ask_for = ($urandom_range(0, 7) != 0);
      rdy_in  = ($urandom_range(0, 7) != 0);
      step();
    end
    rdy_in = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
